aes_round_sequencer: RTL and testbench
======================================

Name: aes_round_sequencer

Overview:
- Iterative AES encryption engine: one shared round datapath (SubBytes, ShiftRows, MixColumns, AddRoundKey) reused over Nr clock cycles instead of Nr unrolled stages.
- Expands the cipher key once into an internal round-key store, one word per cycle, then encrypts any number of blocks under that key.
- Sits between a block source and sink, with valid/ready handshakes on key, input and output.

Parameters:
- Nk, 4, key length in 32-bit words; legal values 4/6/8 (AES-128/192/256).
- Nr, Nk+6, number of rounds; derived, not overridden.

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- key_in  input  Nk*32  cipher key; word 0 in MSBs
- key_valid  input  1  key offer
- key_ready  output  1  key accept window
- in_data  input  128  plaintext block
- in_valid  input  1  plaintext offer
- in_ready  output  1  plaintext accept window
- out_data  output  128  ciphertext
- out_valid  output  1  ciphertext available
- out_ready  input  1  sink accepts ciphertext
- key_loaded  output  1  round-key store valid
- busy  output  1  high in KEXP or ROUND

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values: state=IDLE, out_valid=0, out_data=0, key_loaded=0, busy=0, in_ready=0, key_ready=1. Key store and round counter are cleared.
- States: IDLE, KEXP, READY, ROUND, DONE.
- key_ready=1 only in IDLE and READY. A key handshake (key_valid&&key_ready) latches key_in into w[0..Nk-1], clears key_loaded and enters KEXP.
- KEXP: one word per cycle, for i = Nk .. 4*(Nr+1)-1.
  - temp=w[i-1].
  - If i%Nk==0: temp=SubWord(RotWord(temp))^Rcon.
  - Else if Nk==8 and i%Nk==4: temp=SubWord(temp).
  - w[i]=w[i-Nk]^temp.
  - Rcon is a register starting at 01, updated by xtime after each use; no table.
  - Duration 40/46/52 cycles for Nk=4/6/8. On the last word, set key_loaded=1 and go to READY.
- in_ready = (state==READY) && !key_valid. A pending key has priority over data in the same cycle.
- Input handshake at edge E0 (ROUND entered): state register = in_data ^ w[0..3], round counter = 1.
- ROUND: edges E1..E(Nr-1) apply the full round with w[4r..4r+3]. Edge ENr applies the final round (MixColumns skipped), loads out_data, sets out_valid=1 and enters DONE.
- Latency: out_valid is high in the cycle after ENr, i.e. Nr edges after acceptance (10/12/14). Throughput is one block per Nr+2 cycles with an always-ready sink.
- DONE: out_data and out_valid are held stable while out_ready=0. Output handshake clears out_valid and returns to READY. in_ready cannot rise in the same cycle as the output handshake.
- A new key is accepted only in READY/IDLE. The key store is never modified while a block is in flight.
- key_valid during KEXP, ROUND or DONE is ignored (key_ready=0), with no effect on the current operation.
- rst_n low at any point, mid-KEXP or mid-ROUND:
  - Immediately forces reset values and discards the key.
  - The in-flight block is dropped and no partial output is produced.
  - The key must be reloaded after reset.
- busy=1 exactly in KEXP and ROUND.

Optional Feature:
- Macro AES_SEQ_ZEROIZE_EN.
- Defined: adds input port zeroize (1 bit). A synchronous pulse clears the key store, state register and out_data to zero, drops out_valid, sets key_loaded=0 and enters IDLE on the next edge, from any state. zeroize has priority over every handshake in that cycle.
- Undefined: no zeroize port; key material persists until rst_n or a new key load.

Test Plan:
- Nk=4, key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> out_data 69c4e0d86a7b0430d8cdb78070b4c55a. key_loaded rises 40 cycles after the key handshake; out_valid rises 10 edges after input acceptance.
- Nk=6, key 000102…1617, same pt -> dda97ca4864cdfe06eaf70a0ec0d7191, latency 12. Nk=8, key 000102…1e1f -> 8ea2b7ca516745bfeafc49904b496089, latency 14.
- Nk=4, key 2b7e151628aed2a6abf7158809cf4f3c, then 3 back-to-back blocks (first pt 3243f6a8885a308d313198a2e0370734 -> 3925841d02dc09fbdc118597196a0b32), out_ready held low 5 cycles on block 2 -> out_data stable, in_ready low, no block lost or reordered.
- Checks across states:
  - key_valid and in_valid together in READY -> key accepted, in_ready=0, KEXP entered.
  - key_valid during ROUND -> ignored, current ciphertext correct.
- rst_n asserted at round 5 -> outputs at reset values at once, key_loaded=0. A following in_valid is not accepted until a key reload completes.

Source files
------------

// File: rtl/aes_round_sequencer_if.sv
// aes_round_sequencer_if: key, plaintext and ciphertext handshakes plus status for the iterative AES engine.
interface aes_round_sequencer_if #(
    parameter int NK = 4
);
    logic [NK*32-1:0] key_in;
    logic             key_valid;
    logic             key_ready;
    logic [127:0]     in_data;
    logic             in_valid;
    logic             in_ready;
    logic [127:0]     out_data;
    logic             out_valid;
    logic             out_ready;
    logic             key_loaded;
    logic             busy;
    modport master (
        output key_in, key_valid, in_data, in_valid, out_ready,
        input  key_ready, in_ready, out_data, out_valid, key_loaded, busy
    );
    modport slave (
        input  key_in, key_valid, in_data, in_valid, out_ready,
        output key_ready, in_ready, out_data, out_valid, key_loaded, busy
    );
endinterface

// File: rtl/aes_round_sequencer.sv
// aes_round_sequencer: iterative AES encryptor, one shared round per cycle and an on-chip key expander.
// Defining AES_SEQ_ZEROIZE_EN adds a synchronous zeroize input that wipes all key and data state.
module aes_round_sequencer #(
    parameter int NK = 4
) (
    input logic clk,
    input logic rst_n,
`ifdef AES_SEQ_ZEROIZE_EN
    input logic zeroize,
`endif
    aes_round_sequencer_if.slave bus
);
    localparam int NR = NK + 6;
    localparam int NW = 4 * (NR + 1);
    localparam int IW = $clog2(NW);
    typedef enum logic [2:0] {IDLE, KEXP, READY, ROUND, DONE} state_t;
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            p = b[i] ? p ^ x : p;
            x = xtime(x);
        end
        return p;
    endfunction
    // Inverse computed as x^254 (product of x^2..x^128), so no 256-entry table is needed.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] p;
        logic [7:0] b;
        p = x;
        b = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            b = gf_mul(b, p);
        end
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction
    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction
    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        for (int n = 0; n < 16; n++) o[8*n +: 8] = sbox(s[8*n +: 8]);
        return o;
    endfunction
    // Byte n sits at row n%4, column n/4; row r rotates left by r columns.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int n = 0; n < 16; n++) o[127-8*n -: 8] = s[127-8*(4*(((n/4)+(n%4))%4)+(n%4)) -: 8];
        return o;
    endfunction
    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction
    state_t         r_state, w_next;
    logic [31:0]    r_w [NW];
    logic [IW-1:0]  r_idx;
    logic [2:0]     r_kmod;
    logic [7:0]     r_rcon;
    logic [3:0]     r_rnd;
    logic [127:0]   r_st, r_out;
    logic           r_ov, r_kl;
    logic           w_zero, w_key_rdy, w_in_rdy, w_busy;
    logic           w_key_hs, w_in_hs, w_out_hs;
    logic [31:0]    w_prev, w_sw, w_temp;
    logic [IW-1:0]  w_rb;
    logic [127:0]   w_rk, w_rk0, w_sr, w_round;
`ifdef AES_SEQ_ZEROIZE_EN
    assign w_zero = zeroize;
`else
    assign w_zero = 1'b0;
`endif
    assign w_key_hs = bus.key_valid && w_key_rdy;
    assign w_in_hs  = bus.in_valid && w_in_rdy;
    assign w_out_hs = r_ov && bus.out_ready && !w_zero;
    // Key schedule word i: r_kmod tracks i%NK so Nk=6 needs no divider.
    assign w_prev = r_w[r_idx - IW'(1)];
    assign w_sw   = sub_word(r_kmod == 3'd0 ? {w_prev[23:0], w_prev[31:24]} : w_prev);
    assign w_temp = (r_kmod == 3'd0) ? w_sw ^ {r_rcon, 24'h0} :
                    (NK == 8 && r_kmod == 3'd4) ? w_sw : w_prev;
    assign w_rb    = IW'({r_rnd, 2'b00});
    assign w_rk    = {r_w[w_rb], r_w[w_rb + IW'(1)], r_w[w_rb + IW'(2)], r_w[w_rb + IW'(3)]};
    assign w_rk0   = {r_w[0], r_w[1], r_w[2], r_w[3]};
    assign w_sr    = shift_rows(sub_bytes(r_st));
    assign w_round = (r_rnd == 4'(NR) ? w_sr : mix_columns(w_sr)) ^ w_rk;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else r_state <= w_next;
    end
    always_comb begin
        w_next    = r_state;
        w_key_rdy = 1'b0;
        w_in_rdy  = 1'b0;
        w_busy    = 1'b0;
        case (r_state)
            IDLE: begin
                w_key_rdy = 1'b1;
                w_next    = bus.key_valid ? KEXP : IDLE;
            end
            KEXP: begin
                w_busy = 1'b1;
                w_next = (r_idx == IW'(NW - 1)) ? READY : KEXP;
            end
            READY: begin
                w_key_rdy = 1'b1;
                w_in_rdy  = !bus.key_valid;
                w_next    = bus.key_valid ? KEXP : bus.in_valid ? ROUND : READY;
            end
            ROUND: begin
                w_busy = 1'b1;
                w_next = (r_rnd == 4'(NR)) ? DONE : ROUND;
            end
            DONE: w_next = bus.out_ready ? READY : DONE;
            default: w_next = IDLE;
        endcase
        if (w_zero) begin
            w_next    = IDLE;
            w_key_rdy = 1'b0;
            w_in_rdy  = 1'b0;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < NW; j++) r_w[j] <= '0;
            r_idx  <= IW'(NK);
            r_kmod <= '0;
            r_rcon <= 8'h01;
            r_rnd  <= '0;
            r_st   <= '0;
            r_out  <= '0;
            r_ov   <= 1'b0;
            r_kl   <= 1'b0;
        end else if (w_zero) begin
            for (int j = 0; j < NW; j++) r_w[j] <= '0;
            r_idx  <= IW'(NK);
            r_rnd  <= '0;
            r_st   <= '0;
            r_out  <= '0;
            r_ov   <= 1'b0;
            r_kl   <= 1'b0;
        end else begin
            if (w_key_hs) begin
                for (int j = 0; j < NK; j++) r_w[j] <= bus.key_in[32*(NK-1-j) +: 32];
                r_idx  <= IW'(NK);
                r_kmod <= '0;
                r_rcon <= 8'h01;
                r_kl   <= 1'b0;
            end else if (r_state == KEXP) begin
                r_w[r_idx] <= r_w[r_idx - IW'(NK)] ^ w_temp;
                r_idx  <= (r_idx == IW'(NW - 1)) ? r_idx : r_idx + IW'(1);
                r_kmod <= (r_kmod == 3'(NK - 1)) ? 3'd0 : r_kmod + 3'd1;
                r_rcon <= (r_kmod == 3'd0) ? xtime(r_rcon) : r_rcon;
                r_kl   <= (r_idx == IW'(NW - 1));
            end
            if (w_in_hs) begin
                r_st  <= bus.in_data ^ w_rk0;
                r_rnd <= 4'd1;
            end else if (r_state == ROUND) begin
                r_st  <= w_round;
                r_rnd <= r_rnd + 4'd1;
                if (r_rnd == 4'(NR)) begin
                    r_out <= w_round;
                    r_ov  <= 1'b1;
                end
            end
            if (w_out_hs) r_ov <= 1'b0;
        end
    end
    assign bus.key_ready  = w_key_rdy;
    assign bus.in_ready   = w_in_rdy;
    assign bus.busy       = w_busy;
    assign bus.out_data   = r_out;
    assign bus.out_valid  = r_ov;
    assign bus.key_loaded = r_kl;
endmodule

// File: tb/tb_aes_round_sequencer.sv
// tb_aes_round_sequencer: scoreboard bench; a table-driven AES model predicts each ciphertext.
// Known-answer vectors, random keys/blocks, backpressure, key priority, ignored keys and mid-round reset.
module tb_aes_round_sequencer;
    parameter int NK = 4;
    localparam int NR = NK + 6;
    localparam int NW = 4 * (NR + 1);
    typedef struct { logic [127:0] ct; int acc; } exp_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int cyc = 0, n_chk = 0, n_fail = 0, n_pop = 0;
    exp_t sb_q[$];
    logic [7:0] sb [256];
    int exp_tab [256];
    int log_tab [256];
    logic [NK*32-1:0] key, key2;
    logic [255:0] fips_key;
    logic [127:0] pt;
    aes_round_sequencer_if #(.NK(NK)) bus();
    aes_round_sequencer #(.NK(NK)) dut (
        .clk(clk),
        .rst_n(rst_n),
`ifdef AES_SEQ_ZEROIZE_EN
        .zeroize(1'b0),
`endif
        .bus(bus)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h (cycle %0d)", name, act, req, cyc);
        end
    endtask
    // Flags order: key_ready, in_ready, out_valid, key_loaded, busy.
    task automatic chk_flags(input string name, input logic [4:0] req);
        chk(name, 128'({bus.key_ready, bus.in_ready, bus.out_valid, bus.key_loaded, bus.busy}), 128'(req));
    endtask
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction
    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        if (a == 0 || b == 0) return 8'h00;
        return 8'(exp_tab[(log_tab[a] + log_tab[b]) % 255]);
    endfunction
    task automatic build_tables;
        logic [7:0] p, b, s, c;
        p = 8'h01;
        c = 8'h63;
        for (int i = 0; i < 255; i++) begin
            exp_tab[i] = int'(p);
            log_tab[p] = i;
            p = p ^ xt(p);
        end
        for (int x = 0; x < 256; x++) begin
            b = (x == 0) ? 8'h00 : 8'(exp_tab[(255 - log_tab[x]) % 255]);
            for (int i = 0; i < 8; i++) s[i] = b[i] ^ b[(i+4)%8] ^ b[(i+5)%8] ^ b[(i+6)%8] ^ b[(i+7)%8] ^ c[i];
            sb[x] = s;
        end
    endtask
    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
    endfunction
    function automatic logic [127:0] ref_enc(input logic [NK*32-1:0] k, input logic [127:0] p);
        logic [31:0] w [NW];
        logic [31:0] tmp;
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [7:0] rc;
        logic [127:0] o;
        rc = 8'h01;
        for (int i = 0; i < NK; i++) w[i] = k[32*(NK-1-i) +: 32];
        for (int i = NK; i < NW; i++) begin
            tmp = w[i-1];
            if (i % NK == 0) begin
                tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
                rc = gm(rc, 8'h02);
            end else if (NK > 6 && i % NK == 4) tmp = subw(tmp);
            w[i] = w[i-NK] ^ tmp;
        end
        for (int n = 0; n < 16; n++) s[n] = p[127-8*n -: 8] ^ w[n/4][31-8*(n%4) -: 8];
        for (int r = 1; r <= NR; r++) begin
            for (int n = 0; n < 16; n++) t[n] = sb[s[(n%4) + 4*(((n/4) + (n%4)) % 4)]];
            for (int c = 0; c < 4; c++) begin
                if (r < NR) begin
                    s[4*c]   = gm(t[4*c], 2) ^ gm(t[4*c+1], 3) ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+1] = t[4*c] ^ gm(t[4*c+1], 2) ^ gm(t[4*c+2], 3) ^ t[4*c+3];
                    s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gm(t[4*c+2], 2) ^ gm(t[4*c+3], 3);
                    s[4*c+3] = gm(t[4*c], 3) ^ t[4*c+1] ^ t[4*c+2] ^ gm(t[4*c+3], 2);
                end else for (int j = 0; j < 4; j++) s[4*c+j] = t[4*c+j];
            end
            for (int n = 0; n < 16; n++) s[n] = s[n] ^ w[4*r + n/4][31-8*(n%4) -: 8];
        end
        for (int n = 0; n < 16; n++) o[127-8*n -: 8] = s[n];
        return o;
    endfunction
    function automatic logic [127:0] kat_ct();
        case (NK)
            6: return 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
            8: return 128'h8ea2b7ca516745bfeafc49904b496089;
            default: return 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        endcase
    endfunction
    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction
    function automatic logic [NK*32-1:0] rnd_key();
        logic [NK*32-1:0] k;
        for (int i = 0; i < NK; i++) k[32*i +: 32] = $urandom;
        return k;
    endfunction
    // Monitor: latency on each rising out_valid, ciphertext on each handshake, stability while stalled.
    logic prev_v = 1'b0, prev_stall = 1'b0;
    logic [127:0] prev_d = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_v = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", 128'(bus.out_valid), 128'(1));
                chk("hold_data", bus.out_data, prev_d);
            end
            if (bus.out_valid && !prev_v) begin
                if (sb_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_output: got %h required no output", bus.out_data);
                end else chk("latency", 128'(cyc - sb_q[0].acc), 128'(NR));
            end
            if (bus.out_valid && bus.out_ready && sb_q.size() > 0) begin
                chk("ciphertext", bus.out_data, sb_q[0].ct);
                void'(sb_q.pop_front());
                n_pop++;
            end
            prev_v = bus.out_valid;
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_d = bus.out_data;
        end
    end
    task automatic wait_loaded(input int k0);
        int t;
        for (t = 0; t < 200; t++) begin
            @(negedge clk);
            if (bus.key_loaded) break;
        end
        chk("kexp_cycles", 128'(cyc - k0), 128'(NW - NK));
        @(posedge clk);
        #1;
    endtask
    task automatic load_key(input logic [NK*32-1:0] k);
        int t, k0;
        bus.key_in = k;
        bus.key_valid = 1'b1;
        for (t = 0; t < 200; t++) begin
            @(negedge clk);
            if (bus.key_ready) break;
        end
        if (t == 200) chk("key_accept_timeout", 128'(0), 128'(1));
        @(posedge clk);
        #1;
        k0 = cyc;
        bus.key_valid = 1'b0;
        @(negedge clk);
        chk_flags("kexp_flags", 5'b00001);
        wait_loaded(k0);
    endtask
    task automatic send_block(input logic [127:0] p, input logic [127:0] ct, input bit push);
        int t;
        exp_t e;
        bus.in_data = p;
        bus.in_valid = 1'b1;
        for (t = 0; t < 400; t++) begin
            @(negedge clk);
            if (bus.in_ready) break;
        end
        if (t == 400) chk("in_accept_timeout", 128'(0), 128'(1));
        @(posedge clk);
        #1;
        e.ct = ct;
        e.acc = cyc;
        if (push) sb_q.push_back(e);
        bus.in_valid = 1'b0;
    endtask
    task automatic wait_drain;
        for (int t = 0; t < 3000 && sb_q.size() > 0; t++) @(negedge clk);
        chk("drain_pending", 128'(sb_q.size()), 128'(0));
        @(posedge clk);
        #1;
    endtask
    task automatic stall_second(input int base);
        int t;
        for (t = 0; t < 500; t++) begin
            @(posedge clk);
            #1;
            if (n_pop == base + 1 && bus.out_valid) break;
        end
        if (t == 500) chk("stall_timeout", 128'(0), 128'(1));
        bus.out_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk_flags("stall_flags", 5'b00110);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
    endtask
    task automatic rand_sink(input int target);
        for (int t = 0; t < 4000 && n_pop < target; t++) begin
            @(posedge clk);
            #1;
            bus.out_ready = ($urandom_range(0, 3) != 0);
        end
        bus.out_ready = 1'b1;
    endtask
    initial begin
        int base;
        build_tables();
        bus.key_in = '0;
        bus.key_valid = 1'b0;
        bus.in_data = '0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_flags("reset_flags", 5'b10000);
        chk("reset_out_data", bus.out_data, 128'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk_flags("idle_flags", 5'b10000);
        // Known-answer vector: key bytes 00,01,02,...
        for (int i = 0; i < 4*NK; i++) key[8*(4*NK-1-i) +: 8] = 8'(i);
        load_key(key);
        send_block(128'h00112233445566778899aabbccddeeff, kat_ct(), 1'b1);
        wait_drain();
        // FIPS-197 appendix key, three back-to-back blocks with a 5-cycle stall on the second.
        fips_key = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
        key = fips_key[255 -: NK*32];
        load_key(key);
        pt = 128'h3243f6a8885a308d313198a2e0370734;
        chk("model_fips", ref_enc(key, pt), (NK == 4) ? 128'h3925841d02dc09fbdc118597196a0b32 : ref_enc(key, pt) ^ 128'h0);
        base = n_pop;
        fork
            begin
                send_block(pt, ref_enc(key, pt), 1'b1);
                pt = rnd128();
                send_block(pt, ref_enc(key, pt), 1'b1);
                pt = rnd128();
                send_block(pt, ref_enc(key, pt), 1'b1);
            end
            stall_second(base);
        join
        wait_drain();
        // Random key, random blocks, random sink backpressure.
        key = rnd_key();
        load_key(key);
        base = n_pop;
        fork
            for (int b = 0; b < 8; b++) begin
                pt = rnd128();
                send_block(pt, ref_enc(key, pt), 1'b1);
            end
            rand_sink(base + 8);
        join
        wait_drain();
        // key_valid and in_valid together in READY: key wins.
        key2 = rnd_key();
        bus.key_in = key2;
        bus.key_valid = 1'b1;
        bus.in_data = rnd128();
        bus.in_valid = 1'b1;
        @(negedge clk);
        chk_flags("key_priority", 5'b10010);
        @(posedge clk);
        #1;
        base = cyc;
        bus.key_valid = 1'b0;
        @(negedge clk);
        chk_flags("kexp_entered", 5'b00001);
        bus.in_valid = 1'b0;
        wait_loaded(base);
        key = key2;
        // key_valid during ROUND is ignored.
        pt = rnd128();
        send_block(pt, ref_enc(key, pt), 1'b1);
        bus.key_in = ~key;
        bus.key_valid = 1'b1;
        repeat (NR - 3) begin
            @(negedge clk);
            chk_flags("key_ignored", 5'b00011);
        end
        @(posedge clk);
        #1;
        bus.key_valid = 1'b0;
        wait_drain();
        pt = rnd128();
        send_block(pt, ref_enc(key, pt), 1'b1);
        wait_drain();
        // Asynchronous reset around round 5 drops the block and the key.
        send_block(rnd128(), 128'h0, 1'b0);
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_flags("async_reset", 5'b10000);
        chk("async_reset_data", bus.out_data, 128'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.in_data = rnd128();
        bus.in_valid = 1'b1;
        repeat (NR + 2) begin
            @(negedge clk);
            chk_flags("no_key_after_reset", 5'b10000);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        load_key(key);
        pt = rnd128();
        send_block(pt, ref_enc(key, pt), 1'b1);
        wait_drain();
        repeat (5) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
